// File: rtl/dmem_arbiter.sv
// dmem_arbiter: round-robin arbiter/sequencer sharing one fixed-latency data memory port.
// Rev 1.0 - initial release.
`default_nettype none

module dmem_arbiter #(
   parameter int N_REQ   = 2,
   parameter int AW      = 32,
   parameter int DW      = 32,
   parameter int MEM_LAT = 1
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic [N_REQ-1:0]    req,
   input  logic [N_REQ-1:0]    req_we,
   input  logic [N_REQ*AW-1:0] req_addr,
   input  logic [N_REQ*DW-1:0] req_wdata,
   output logic [N_REQ-1:0]    gnt,
   output logic [N_REQ-1:0]    done,
   output logic [DW-1:0]       rdata,
   output logic [N_REQ-1:0]    stall,
   output logic                busy,
   output logic                mem_en,
   output logic                mem_we,
   output logic [AW-1:0]       mem_addr,
   output logic [DW-1:0]       mem_wdata,
   input  logic [DW-1:0]       mem_rdata
);

   localparam int IW  = (N_REQ > 1) ? $clog2(N_REQ) : 1;
   localparam int IW1 = IW + 1;
   localparam int CW  = $clog2(MEM_LAT + 1);
   localparam logic [IW:0]   NREQ_W = IW1'(N_REQ);
   localparam logic [IW-1:0] LAST_W = IW'(N_REQ - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_WAIT   = 2'd2,
      S_DONE   = 2'd3
   } state_e;

   state_e          state_q, state_d;
   logic [IW-1:0]   cur_q, cur_d;
   logic [IW-1:0]   rr_q, rr_d;
   logic            we_q, we_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [DW-1:0]   rdata_q, rdata_d;

   logic            found;
   logic [IW-1:0]   win;
   logic [IW:0]     scan_idx;

   // Scan upward from the last winner so the previous owner ranks last.
   always_comb begin
      found    = 1'b0;
      win      = rr_q;
      scan_idx = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         scan_idx = {1'b0, rr_q} + IW1'(k);
         if (scan_idx >= NREQ_W) scan_idx = scan_idx - NREQ_W;
         if (!found && req[scan_idx[IW-1:0]]) begin
            found = 1'b1;
            win   = scan_idx[IW-1:0];
         end
      end
   end

   always_comb begin
      state_d = state_q;
      cur_d   = cur_q;
      rr_d    = rr_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      cnt_d   = cnt_q;
      rdata_d = rdata_q;
      case (state_q)
         S_IDLE: begin
            if (found) begin
               cur_d   = win;
               rr_d    = win;
               we_d    = req_we[win];
               addr_d  = req_addr[int'(win)*AW +: AW];
               wdata_d = req_wdata[int'(win)*DW +: DW];
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            cnt_d   = CW'(MEM_LAT);
            state_d = S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - CW'(1);
            if (cnt_q == CW'(1)) begin
               if (!we_q) rdata_d = mem_rdata;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cur_q   <= '0;
         rr_q    <= LAST_W;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
         cnt_q   <= '0;
         rdata_q <= '0;
      end else begin
         state_q <= state_d;
         cur_q   <= cur_d;
         rr_q    <= rr_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
      end
   end

   // Strobes decode straight from state so an async reset clears them at once.
   always_comb begin
      gnt  = '0;
      done = '0;
      if (state_q == S_ACCESS) gnt[cur_q]  = 1'b1;
      if (state_q == S_DONE)   done[cur_q] = 1'b1;
   end

   assign mem_en    = (state_q == S_ACCESS);
   assign mem_we    = mem_en & we_q;
   assign mem_addr  = addr_q;
   assign mem_wdata = wdata_q;
   assign rdata     = rdata_q;
   assign busy      = (state_q != S_IDLE);
   assign stall     = req & ~done;

endmodule

`default_nettype wire

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed-vector bench for dmem_arbiter (2x LAT1, 2x LAT3, 4x LAT1 instances).
// Rev 1.0 - initial release.
`default_nettype none

module tb_dmem_arbiter;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] mem_val(input logic [31:0] a);
      return (a == 32'h10) ? 32'hDEADBEEF : {16'hA5A5, a[15:0]};
   endfunction

   function automatic int oh2i(input logic [3:0] v);
      int r = -1;
      for (int i = 0; i < 4; i++) if (v[i]) r = i;
      return r;
   endfunction

   // Instance A: N_REQ=2, MEM_LAT=1
   logic [1:0]  req_a = '0, we_a = '0;
   logic [63:0] addr_a = '0, wdata_a = '0;
   logic [1:0]  gnt_a, done_a, stall_a;
   logic [31:0] rdata_a, maddr_a, mwdata_a;
   logic [31:0] mrdata_a;
   logic        busy_a, men_a, mwe_a;

   dmem_arbiter #(.N_REQ(2), .AW(32), .DW(32), .MEM_LAT(1)) u_a (
      .clk(clk), .rst_n(rst_n), .req(req_a), .req_we(we_a), .req_addr(addr_a),
      .req_wdata(wdata_a), .gnt(gnt_a), .done(done_a), .rdata(rdata_a), .stall(stall_a),
      .busy(busy_a), .mem_en(men_a), .mem_we(mwe_a), .mem_addr(maddr_a),
      .mem_wdata(mwdata_a), .mem_rdata(mrdata_a));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mrdata_a <= '0;
      else        mrdata_a <= (men_a && !mwe_a) ? mem_val(maddr_a) : 32'h0;

   // Instance B: N_REQ=2, MEM_LAT=3
   logic [1:0]  req_b = '0, we_b = '0;
   logic [63:0] addr_b = '0, wdata_b = '0;
   logic [1:0]  gnt_b, done_b, stall_b;
   logic [31:0] rdata_b, maddr_b, mwdata_b, mrdata_b;
   logic        busy_b, men_b, mwe_b;
   logic [2:0]  bv;
   logic [31:0] ba [3];

   dmem_arbiter #(.N_REQ(2), .AW(32), .DW(32), .MEM_LAT(3)) u_b (
      .clk(clk), .rst_n(rst_n), .req(req_b), .req_we(we_b), .req_addr(addr_b),
      .req_wdata(wdata_b), .gnt(gnt_b), .done(done_b), .rdata(rdata_b), .stall(stall_b),
      .busy(busy_b), .mem_en(men_b), .mem_we(mwe_b), .mem_addr(maddr_b),
      .mem_wdata(mwdata_b), .mem_rdata(mrdata_b));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         bv <= '0;
         ba[0] <= '0; ba[1] <= '0; ba[2] <= '0;
      end else begin
         bv    <= {bv[1:0], men_b & ~mwe_b};
         ba[0] <= maddr_b;
         ba[1] <= ba[0];
         ba[2] <= ba[1];
      end
   assign mrdata_b = bv[2] ? mem_val(ba[2]) : 32'h0;

   // Instance C: N_REQ=4, MEM_LAT=1
   logic [3:0]   req_c = '0, we_c = '0;
   logic [127:0] addr_c = '0, wdata_c = '0;
   logic [3:0]   gnt_c, done_c, stall_c;
   logic [31:0]  rdata_c, maddr_c, mwdata_c;
   logic [31:0]  mrdata_c;
   logic         busy_c, men_c, mwe_c;

   dmem_arbiter #(.N_REQ(4), .AW(32), .DW(32), .MEM_LAT(1)) u_c (
      .clk(clk), .rst_n(rst_n), .req(req_c), .req_we(we_c), .req_addr(addr_c),
      .req_wdata(wdata_c), .gnt(gnt_c), .done(done_c), .rdata(rdata_c), .stall(stall_c),
      .busy(busy_c), .mem_en(men_c), .mem_we(mwe_c), .mem_addr(maddr_c),
      .mem_wdata(mwdata_c), .mem_rdata(mrdata_c));

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) mrdata_c <= '0;
      else        mrdata_c <= (men_c && !mwe_c) ? mem_val(maddr_c) : 32'h0;

   task automatic do_reset();
      rst_n = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
   endtask

   int ng, last_done, done_cyc, en_cnt;
   logic [3:0] dl;
   int exp3 [4] = '{0, 1, 0, 1};
   int exp6 [7] = '{0, 1, 2, 3, 0, 1, 3};

   initial begin
      // Reset state, checked while reset is held
      #3;
      chk("rst gnt",   32'(gnt_a), 32'h0);
      chk("rst done",  32'(done_a), 32'h0);
      chk("rst mem_en", 32'(men_a), 32'h0);
      chk("rst busy",  32'(busy_a), 32'h0);
      chk("rst rdata", rdata_a, 32'h0);
      chk("rst maddr", maddr_a, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;

      // Single read by requester 0
      @(posedge clk); #1;
      req_a = 2'b01; we_a = 2'b00; addr_a[31:0] = 32'h10;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t1 stall0", 32'(stall_a[0]), 32'(c < 3));
         chk("t1 gnt", 32'(gnt_a), (c == 1) ? 32'h1 : 32'h0);
         chk("t1 mem_en", 32'(men_a), 32'(c == 1));
         chk("t1 done", 32'(done_a), (c == 3) ? 32'h1 : 32'h0);
         if (c == 1) begin
            chk("t1 maddr", maddr_a, 32'h10);
            chk("t1 mwe", 32'(mwe_a), 32'h0);
         end
      end
      chk("t1 rdata", rdata_a, 32'hDEADBEEF);

      // Write by requester 1; rdata must be untouched
      @(posedge clk); #1;
      req_a = 2'b10; we_a = 2'b10; addr_a[63:32] = 32'h20; wdata_a[63:32] = 32'h12345678;
      for (int c = 0; c < 4; c++) begin
         @(negedge clk);
         chk("t2 gnt", 32'(gnt_a), (c == 1) ? 32'h2 : 32'h0);
         chk("t2 mem_en", 32'(men_a), 32'(c == 1));
         chk("t2 mwe", 32'(mwe_a), 32'(c == 1));
         chk("t2 done", 32'(done_a), (c == 3) ? 32'h2 : 32'h0);
         if (c == 1) begin
            chk("t2 mwdata", mwdata_a, 32'h12345678);
            chk("t2 maddr", maddr_a, 32'h20);
         end
      end
      chk("t2 rdata", rdata_a, 32'hDEADBEEF);
      @(posedge clk); #1;
      req_a = 2'b00; we_a = 2'b00;

      // Both requesters contending, each dropping one cycle after its done
      do_reset();
      req_a = 2'b11; addr_a = {32'h200, 32'h100};
      ng = 0; last_done = -1;
      for (int c = 0; c < 16; c++) begin
         @(negedge clk);
         chk("t3 onehot", 32'($onehot0(gnt_a)), 32'h1);
         if (gnt_a != 2'b00) begin
            if (ng < 4) chk("t3 order", 32'(oh2i(4'(gnt_a))), 32'(exp3[ng]));
            ng++;
         end
         if (done_a != 2'b00) begin
            if (last_done >= 0) chk("t3 spacing", 32'(c - last_done), 32'd4);
            last_done = c;
         end
         dl = 4'(done_a);
         @(posedge clk); #1;
         req_a = 2'b11 & ~dl[1:0];
      end
      req_a = 2'b00;
      chk("t3 grants", 32'(ng), 32'd4);
      chk("t3 last done", 32'(last_done), 32'd15);

      // MEM_LAT=3 single read
      repeat (2) @(posedge clk);
      #1;
      req_b = 2'b01; we_b = 2'b00; addr_b[31:0] = 32'h44;
      en_cnt = 0; done_cyc = -1;
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         if (men_b) en_cnt++;
         if (c == 1) chk("t4 maddr", maddr_b, 32'h44);
         if (done_b[0]) done_cyc = c;
         dl = 4'(done_b);
         @(posedge clk); #1;
         if (dl[0]) req_b = 2'b00;
      end
      chk("t4 en count", 32'(en_cnt), 32'd1);
      chk("t4 done cyc", 32'(done_cyc), 32'd5);
      chk("t4 rdata", rdata_b, 32'hA5A50044);

      // Reset during WAIT, then requester 1 alone
      req_b = 2'b01; addr_b[31:0] = 32'h48;
      repeat (3) @(negedge clk);
      chk("t5 busy pre", 32'(busy_b), 32'h1);
      #1 rst_n = 1'b0;
      #1;
      chk("t5 busy", 32'(busy_b), 32'h0);
      chk("t5 mem_en", 32'(men_b), 32'h0);
      chk("t5 gnt", 32'(gnt_b), 32'h0);
      chk("t5 done", 32'(done_b), 32'h0);
      chk("t5 rdata", rdata_b, 32'h0);
      @(posedge clk); #1;
      rst_n = 1'b1;
      req_b = 2'b10; addr_b[63:32] = 32'h80;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         chk("t5 no done0", 32'(done_b[0]), 32'h0);
         chk("t5 gnt1", 32'(gnt_b), (c == 1) ? 32'h2 : 32'h0);
         chk("t5 done1", 32'(done_b[1]), 32'(c == 5));
      end
      chk("t5 rdata1", rdata_b, 32'hA5A50080);
      @(posedge clk); #1;
      req_b = 2'b00;

      // N_REQ=4 rotation, then req[2] dropped while 1 is in service
      @(posedge clk); #1;
      req_c = 4'b1111;
      addr_c = {32'h300, 32'h200, 32'h100, 32'h010};
      ng = 0;
      for (int c = 0; c < 27; c++) begin
         @(negedge clk);
         chk("t6 onehot", 32'($onehot0(gnt_c)), 32'h1);
         dl = 4'b0000;
         if (gnt_c != 4'b0000) begin
            if (ng < 7) chk("t6 order", 32'(oh2i(gnt_c)), 32'(exp6[ng]));
            ng++;
            if (ng == 6 && gnt_c == 4'b0010) dl = 4'b0100;
         end
         @(posedge clk); #1;
         req_c = req_c & ~dl;
      end
      req_c = 4'b0000;
      chk("t6 grants", 32'(ng), 32'd7);

      repeat (3) @(posedge clk);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Round-robin arbiter and sequencer for the single-port data memory, shared among N_REQ requesters: core data ports of the NoC tiles plus the network interface DMA.
- Accepts one request at a time over a req/done handshake.
- Drives a single memory access port with fixed read latency MEM_LAT and returns read data.
- Provides per-requester stall outputs so pipelines can freeze their MEM stage while waiting.

Parameters:
- N_REQ, 2, number of requesters (>=2)
- AW, 32, address width
- DW, 32, data width
- MEM_LAT, 1, cycles from the mem_en cycle to valid mem_rdata (>=1; 1 = synchronous RAM)

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- req  in  N_REQ  request; held high until done[i]
- req_we  in  N_REQ  1 = write, 0 = read
- req_addr  in  N_REQ*AW  requester i at [i*AW +: AW]
- req_wdata  in  N_REQ*DW  requester i at [i*DW +: DW]
- gnt  out  N_REQ  one-hot pulse, request accepted (ACCESS cycle)
- done  out  N_REQ  one-hot one-cycle completion pulse
- rdata  out  DW  read data, valid with done, held until next read completes
- stall  out  N_REQ  combinational: req[i] & ~done[i]
- busy  out  1  state != IDLE
- mem_en  out  1  memory access strobe, exactly one cycle per transaction
- mem_we  out  1  memory write enable, qualified by mem_en
- mem_addr  out  AW  memory address
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data, valid MEM_LAT cycles after mem_en

Behaviour:
- Reset (async, immediate): state IDLE; gnt, done, mem_en, mem_we = 0; mem_addr, mem_wdata, rdata = 0; cnt = 0; rr_ptr = N_REQ-1, so requester 0 wins first.
- State IDLE:
  - If any req bit is set, the winner is the first set bit searching from rr_ptr+1 upward, wrapping modulo N_REQ.
  - Latch cur = winner, plus that requester's we/addr/wdata into internal regs; rr_ptr <= winner; go to ACCESS.
  - If no req bit is set, stay in IDLE.
- State ACCESS (1 cycle):
  - mem_en = 1; mem_we/mem_addr/mem_wdata from the latched regs; gnt[cur] = 1.
  - cnt <= MEM_LAT; go to WAIT.
- State WAIT:
  - cnt decrements each cycle.
  - In the cycle cnt == 1, mem_rdata is valid: if the latched op is a read, rdata <= mem_rdata; go to DONE.
  - mem_en = 0 throughout.
- State DONE (1 cycle): done[cur] = 1; go to IDLE. No arbitration in DONE, so the requester's req drop is seen before the next grant.
- Latency, read or write: req sampled in IDLE at cycle 0 → ACCESS at cycle 1 → done at cycle MEM_LAT+2.
- Throughput: one transaction per MEM_LAT+3 cycles with back-to-back requests.
- Outputs driven outside ACCESS: mem_addr/mem_wdata hold their last values; mem_we = 0 when mem_en = 0.
- Writes never modify rdata.
- A request arriving during a transaction is held pending; it is arbitrated in the next IDLE cycle.
- Simultaneous requests are resolved by round-robin only; no priority inversion, no starvation (maximum wait (N_REQ-1) transactions).
- req deasserted mid-transaction (protocol violation): the transaction completes from the latched regs and done still pulses.
- req/addr changes after the IDLE sample are ignored.
- Reset mid-operation: the transaction is abandoned with no done pulse; requesters must reissue. mem_en drops immediately.
- stall[i] is purely combinational: it falls in the done cycle so the requester pipeline advances on that edge.

Test Plan:
- MEM_LAT=1, req[0] read addr 0x10, memory model returns 0xDEADBEEF → gnt[0] and mem_en at cycle 1 with mem_addr 0x10, mem_we 0; done[0] and rdata=0xDEADBEEF at cycle 3; stall[0]=1 cycles 0-2, 0 at cycle 3.
- req[1] write addr 0x20 wdata 0x12345678 → mem_en, mem_we=1, mem_wdata 0x12345678 at cycle 1; done[1] at cycle 3; rdata unchanged from prior value.
- req[0] and req[1] held continuously from reset release, each deasserting for one cycle after its done → grant order 0,1,0,1; each done spaced 4 cycles; no double grant.
- MEM_LAT=3, single read → exactly one mem_en cycle; done at cycle 5; rdata equals mem_rdata sampled 3 cycles after mem_en.
- rst_n asserted during WAIT → mem_en, gnt, done, busy, rdata go to 0 without waiting for a clock edge; no done pulse. After release with only req[1] high → gnt[1] at cycle 1.
- N_REQ=4, all req high → grants 0,1,2,3,0. If req[2] is dropped while 1 is in service, the next grant goes to 3.
